// File: rtl/pulse_meter_if.sv
// Bus between the control side and pulse_meter: arm/mode/signal in,
// measurement result and status out.
interface pulse_meter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             sig;
  logic [WIDTH-1:0] q;
  logic             done;
  logic             busy;
  logic             ovf;

  modport master (
    output start, mode, sig,
    input  q, done, busy, ovf
  );

  modport slave (
    input  start, mode, sig,
    output q, done, busy, ovf
  );
endinterface

// File: rtl/pulse_meter.sv
// Measures high-pulse width (mode 0) or rising-to-rising period (mode 1) of a
// synchronous signal in clock cycles, saturating at 2^WIDTH-1.
module pulse_meter #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] CntMax = '1;

  state_e           state_q;
  logic             sigPrev_q;
  logic [WIDTH-1:0] cnt_q;
  logic             modeReg_q;
  logic             ovfRun_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             ovf_q;

  logic             riseEdge;
  logic             cntSat;
  logic             measureEnd;

  assign riseEdge   = bus.sig & ~sigPrev_q;
  assign cntSat     = (cnt_q == CntMax);
  // Width mode closes on the first low sample, period mode on the next rising edge.
  assign measureEnd = modeReg_q ? riseEdge : ~bus.sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sigPrev_q <= 1'b0;
      cnt_q     <= '0;
      modeReg_q <= 1'b0;
      ovfRun_q  <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sigPrev_q <= bus.sig;
      done_q    <= 1'b0;
      // Arming wins over any edge, so a re-arm silently discards the run.
      if (bus.start) begin
        state_q   <= ARMED;
        cnt_q     <= '0;
        ovfRun_q  <= 1'b0;
        modeReg_q <= bus.mode;
      end else begin
        case (state_q)
          IDLE: ;
          ARMED: begin
            if (riseEdge) begin
              state_q <= MEASURE;
              cnt_q   <= WIDTH'(1);
            end
          end
          MEASURE: begin
            if (measureEnd) begin
              result_q <= cnt_q;
              ovf_q    <= ovfRun_q;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end else if (cntSat) begin
              ovfRun_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + WIDTH'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.q    = result_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule
